// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input
// in i_clk cycles, reporting each complete period with a one-cycle strobe.
module pwm_capture #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pwm,
  input  logic                 i_enable,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic [CNT_WIDTH-1:0] o_high,
  output logic                 o_valid,
  output logic                 o_timeout,
  output logic                 o_level
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_WIDTH-1:0]   period_cnt;
  logic [CNT_WIDTH-1:0]   high_cnt;
  logic [CNT_WIDTH-1:0]   high_hold;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign o_level = s;

  // Edge strobes are registered so the FSM acts one cycle after the edge is seen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
      s_d    <= s;
      rise_q <= rise;
      fall_q <= fall;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      high_hold  <= '0;
      o_period   <= '0;
      o_high     <= '0;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_enable) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
        high_hold  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise_q) begin
              state      <= HIGH;
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
            end
          end
          HIGH: begin
            // Saturation wins over any edge arriving in the same cycle.
            if (period_cnt == CNT_MAX) begin
              state      <= IDLE;
              o_timeout  <= 1'b1;
              period_cnt <= '0;
              high_cnt   <= '0;
              high_hold  <= '0;
            end else if (fall_q) begin
              state      <= LOW;
              high_hold  <= high_cnt;
              period_cnt <= period_cnt + CNT_ONE;
            end else begin
              period_cnt <= period_cnt + CNT_ONE;
              high_cnt   <= high_cnt + CNT_ONE;
            end
          end
          LOW: begin
            if (period_cnt == CNT_MAX) begin
              state      <= IDLE;
              o_timeout  <= 1'b1;
              period_cnt <= '0;
              high_cnt   <= '0;
              high_hold  <= '0;
            end else if (rise_q) begin
              state      <= HIGH;
              o_period   <= period_cnt;
              o_high     <= high_hold;
              o_valid    <= 1'b1;
              o_timeout  <= 1'b0;
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
            end else begin
              period_cnt <= period_cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
